// File: rtl/cam_param.sv
// cam_param: parametrised content-addressable memory with registered search
// results, masked search, per-entry invalidate, flush and free-slot allocation.
// Ports:
//   clk, rst_i (async active-low)
//   write_enable_i/write_index_i/write_data_i : explicit write, entry becomes valid
//   alloc_i -> alloc_ok_o/alloc_index_o (registered), full_o (combinational)
//   invalidate_i/invalidate_index_i, flush_i : valid-bit clearing
//   read_index_i -> read_value_o/read_valid_o (combinational)
//   search_enable_i/search_data_i/search_mask_i -> search_valid_o/search_index_o/
//     search_multi_o/search_count_o (registered, one cycle after the search edge)
module cam_param #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             write_enable_i,
  input  logic [IDX_W-1:0] write_index_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic             alloc_i,
  output logic             alloc_ok_o,
  output logic [IDX_W-1:0] alloc_index_o,
  output logic             full_o,
  input  logic             invalidate_i,
  input  logic [IDX_W-1:0] invalidate_index_i,
  input  logic             flush_i,
  input  logic [IDX_W-1:0] read_index_i,
  output logic [WIDTH-1:0] read_value_o,
  output logic             read_valid_o,
  input  logic             search_enable_i,
  input  logic [WIDTH-1:0] search_data_i,
  input  logic [WIDTH-1:0] search_mask_i,
  output logic             search_valid_o,
  output logic [IDX_W-1:0] search_index_o,
  output logic             search_multi_o,
  output logic [CNT_W-1:0] search_count_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;

  logic             alloc_ok_q, alloc_ok_d;
  logic [IDX_W-1:0] alloc_index_q, alloc_index_d;

  logic             search_valid_q, search_valid_d;
  logic [IDX_W-1:0] search_index_q, search_index_d;
  logic             search_multi_q, search_multi_d;
  logic [CNT_W-1:0] search_count_q, search_count_d;

  logic [DEPTH-1:0] hit_c;
  logic [IDX_W-1:0] hit_idx_c;
  logic [CNT_W-1:0] hit_cnt_c;
  logic             hit_found_c;

  logic [IDX_W-1:0] free_idx_c;
  logic             free_found_c;

  // Full flag tracks the current valid bits.
  assign full_o = &valid_q;

  // Combinational read; indices with no backing entry read as zero.
  always_comb begin
    read_value_o = '0;
    read_valid_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (read_index_i == IDX_W'(i)) begin
        read_value_o = data_q[i];
        read_valid_o = valid_q[i];
      end
    end
  end

  // Match vector, lowest-hit priority encoder and hit population count.
  always_comb begin
    hit_idx_c   = '0;
    hit_cnt_c   = '0;
    hit_found_c = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit_c[i] = valid_q[i] && (((data_q[i] ^ search_data_i) & search_mask_i) == '0);
      hit_cnt_c = hit_cnt_c + CNT_W'(hit_c[i]);
      if (hit_c[i] && !hit_found_c) begin
        hit_idx_c   = IDX_W'(i);
        hit_found_c = 1'b1;
      end
    end
  end

  // Lowest free entry, from pre-edge valid bits.
  always_comb begin
    free_idx_c   = '0;
    free_found_c = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!valid_q[i] && !free_found_c) begin
        free_idx_c   = IDX_W'(i);
        free_found_c = 1'b1;
      end
    end
  end

  // Next-state for the array and the registered result outputs.
  always_comb begin
    data_d         = data_q;
    valid_d        = valid_q;
    alloc_ok_d     = 1'b0;
    alloc_index_d  = '0;
    search_valid_d = 1'b0;
    search_index_d = '0;
    search_multi_d = 1'b0;
    search_count_d = '0;

    if (flush_i) begin
      valid_d = '0;
    end else begin
      // Invalidate first so a same-index write overrides it.
      if (invalidate_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (invalidate_index_i == IDX_W'(i)) valid_d[i] = 1'b0;
        end
      end
      if (write_enable_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (write_index_i == IDX_W'(i)) begin
            data_d[i]  = write_data_i;
            valid_d[i] = 1'b1;
          end
        end
      end else if (alloc_i && free_found_c) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (free_idx_c == IDX_W'(i)) begin
            data_d[i]  = write_data_i;
            valid_d[i] = 1'b1;
          end
        end
        alloc_ok_d    = 1'b1;
        alloc_index_d = free_idx_c;
      end
    end

    // Search sees only pre-edge state; results live for one cycle.
    if (search_enable_i) begin
      search_valid_d = hit_found_c;
      search_index_d = hit_idx_c;
      search_multi_d = (hit_cnt_c > CNT_W'(1));
      search_count_d = hit_cnt_c;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= '0;
      valid_q        <= '0;
      alloc_ok_q     <= 1'b0;
      alloc_index_q  <= '0;
      search_valid_q <= 1'b0;
      search_index_q <= '0;
      search_multi_q <= 1'b0;
      search_count_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) data_q[i] <= data_d[i];
      valid_q        <= valid_d;
      alloc_ok_q     <= alloc_ok_d;
      alloc_index_q  <= alloc_index_d;
      search_valid_q <= search_valid_d;
      search_index_q <= search_index_d;
      search_multi_q <= search_multi_d;
      search_count_q <= search_count_d;
    end
  end

  assign alloc_ok_o     = alloc_ok_q;
  assign alloc_index_o  = alloc_index_q;
  assign search_valid_o = search_valid_q;
  assign search_index_o = search_index_q;
  assign search_multi_o = search_multi_q;
  assign search_count_o = search_count_q;

endmodule

// File: tb/tb_cam_param.sv
// Directed bench for cam_param (WIDTH=32, DEPTH=32).
module tb_cam_param;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned CW = 6;

  logic          clk;
  logic          rst_i;
  logic          write_enable_i;
  logic [IW-1:0] write_index_i;
  logic [W-1:0]  write_data_i;
  logic          alloc_i;
  logic          alloc_ok_o;
  logic [IW-1:0] alloc_index_o;
  logic          full_o;
  logic          invalidate_i;
  logic [IW-1:0] invalidate_index_i;
  logic          flush_i;
  logic [IW-1:0] read_index_i;
  logic [W-1:0]  read_value_o;
  logic          read_valid_o;
  logic          search_enable_i;
  logic [W-1:0]  search_data_i;
  logic [W-1:0]  search_mask_i;
  logic          search_valid_o;
  logic [IW-1:0] search_index_o;
  logic          search_multi_o;
  logic [CW-1:0] search_count_o;

  int checks = 0;
  int errors = 0;

  cam_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clk                (clk),
    .rst_i              (rst_i),
    .write_enable_i     (write_enable_i),
    .write_index_i      (write_index_i),
    .write_data_i       (write_data_i),
    .alloc_i            (alloc_i),
    .alloc_ok_o         (alloc_ok_o),
    .alloc_index_o      (alloc_index_o),
    .full_o             (full_o),
    .invalidate_i       (invalidate_i),
    .invalidate_index_i (invalidate_index_i),
    .flush_i            (flush_i),
    .read_index_i       (read_index_i),
    .read_value_o       (read_value_o),
    .read_valid_o       (read_valid_o),
    .search_enable_i    (search_enable_i),
    .search_data_i      (search_data_i),
    .search_mask_i      (search_mask_i),
    .search_valid_o     (search_valid_o),
    .search_index_o     (search_index_o),
    .search_multi_o     (search_multi_o),
    .search_count_o     (search_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable_i     = 1'b0;
    write_index_i      = '0;
    write_data_i       = '0;
    alloc_i            = 1'b0;
    invalidate_i       = 1'b0;
    invalidate_index_i = '0;
    flush_i            = 1'b0;
    search_enable_i    = 1'b0;
    search_data_i      = '0;
    search_mask_i      = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    read_index_i = '0;
    idle();
    cycle();
    cycle();
    checks++;
    if ({search_valid_o, search_multi_o, search_count_o, search_index_o, alloc_ok_o, alloc_index_o} !== '0) begin
      errors++;
      $display("FAIL reset_regs got sv=%0b sm=%0b sc=%0d si=%0d ao=%0b ai=%0d exp all 0",
               search_valid_o, search_multi_o, search_count_o, search_index_o, alloc_ok_o, alloc_index_o);
    end
    rst_i = 1'b1;
    cycle();
    search_enable_i = 1'b1;
    search_data_i   = 32'h0;
    search_mask_i   = 32'hFFFF_FFFF;
    cycle();
    idle();
    checks++;
    if (search_valid_o !== 1'b0 || search_count_o !== 6'd0) begin
      errors++;
      $display("FAIL reset_search got valid=%0b count=%0d exp 0 0", search_valid_o, search_count_o);
    end
    checks++;
    if (full_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_full got %0b exp 0", full_o);
    end
    for (int i = 0; i < int'(D); i++) begin
      read_index_i = IW'(i);
      #1;
      checks++;
      if (read_valid_o !== 1'b0 || read_value_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_read[%0d] got valid=%0b value=%h exp 0 0", i, read_valid_o, read_value_o);
      end
    end
  endtask

  task automatic test_multi_hit();
    write_enable_i = 1'b1; write_index_i = 5'd5; write_data_i = 32'hDEAD_BEEF;
    cycle();
    write_index_i = 5'd9;
    cycle();
    idle();
    search_enable_i = 1'b1; search_data_i = 32'hDEAD_BEEF; search_mask_i = 32'hFFFF_FFFF;
    cycle();
    idle();
    checks++;
    if (search_valid_o !== 1'b1 || search_index_o !== 5'd5 || search_multi_o !== 1'b1 || search_count_o !== 6'd2) begin
      errors++;
      $display("FAIL multi_hit got v=%0b i=%0d m=%0b c=%0d exp 1 5 1 2",
               search_valid_o, search_index_o, search_multi_o, search_count_o);
    end
    cycle();
    checks++;
    if ({search_valid_o, search_index_o, search_multi_o, search_count_o} !== '0) begin
      errors++;
      $display("FAIL idle_search got v=%0b i=%0d m=%0b c=%0d exp 0 0 0 0",
               search_valid_o, search_index_o, search_multi_o, search_count_o);
    end
  endtask

  task automatic test_masked();
    write_enable_i = 1'b1; write_index_i = 5'd3; write_data_i = 32'h1234_5678;
    cycle();
    idle();
    search_enable_i = 1'b1; search_data_i = 32'h1234_0000; search_mask_i = 32'hFFFF_0000;
    cycle();
    checks++;
    if (search_valid_o !== 1'b1 || search_index_o !== 5'd3 || search_multi_o !== 1'b0 || search_count_o !== 6'd1) begin
      errors++;
      $display("FAIL masked_hit got v=%0b i=%0d m=%0b c=%0d exp 1 3 0 1",
               search_valid_o, search_index_o, search_multi_o, search_count_o);
    end
    search_mask_i = 32'hFFFF_FFFF;
    cycle();
    checks++;
    if (search_valid_o !== 1'b0 || search_index_o !== 5'd0 || search_count_o !== 6'd0) begin
      errors++;
      $display("FAIL full_mask_miss got v=%0b i=%0d c=%0d exp 0 0 0", search_valid_o, search_index_o, search_count_o);
    end
    search_mask_i = 32'h0;
    cycle();
    idle();
    checks++;
    if (search_valid_o !== 1'b1 || search_index_o !== 5'd3 || search_multi_o !== 1'b1 || search_count_o !== 6'd3) begin
      errors++;
      $display("FAIL zero_mask got v=%0b i=%0d m=%0b c=%0d exp 1 3 1 3",
               search_valid_o, search_index_o, search_multi_o, search_count_o);
    end
  endtask

  task automatic test_alloc();
    flush_i = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < int'(D); i++) begin
      alloc_i = 1'b1; write_data_i = 32'(i);
      cycle();
      checks++;
      if (alloc_ok_o !== 1'b1 || alloc_index_o !== IW'(i)) begin
        errors++;
        $display("FAIL alloc[%0d] got ok=%0b idx=%0d exp 1 %0d", i, alloc_ok_o, alloc_index_o, i);
      end
    end
    idle();
    checks++;
    if (full_o !== 1'b1) begin
      errors++;
      $display("FAIL full_after_alloc got %0b exp 1", full_o);
    end
    alloc_i = 1'b1; write_data_i = 32'hFFFF_FFFF;
    cycle();
    idle();
    checks++;
    if (alloc_ok_o !== 1'b0 || alloc_index_o !== 5'd0) begin
      errors++;
      $display("FAIL alloc_when_full got ok=%0b idx=%0d exp 0 0", alloc_ok_o, alloc_index_o);
    end
    read_index_i = 5'd0;
    #1;
    checks++;
    if (read_value_o !== 32'h0 || read_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL full_no_write[0] got %h/%0b exp 00000000/1", read_value_o, read_valid_o);
    end
    read_index_i = 5'd31;
    #1;
    checks++;
    if (read_value_o !== 32'd31) begin
      errors++;
      $display("FAIL full_no_write[31] got %h exp 0000001f", read_value_o);
    end
  endtask

  task automatic test_inval_alloc();
    invalidate_i = 1'b1; invalidate_index_i = 5'd7;
    alloc_i = 1'b1; write_data_i = 32'h777;
    cycle();
    idle();
    checks++;
    if (alloc_ok_o !== 1'b0 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL inval_alloc got ok=%0b full=%0b exp 0 0", alloc_ok_o, full_o);
    end
    alloc_i = 1'b1; write_data_i = 32'h777;
    cycle();
    idle();
    read_index_i = 5'd7;
    #1;
    checks++;
    if (alloc_ok_o !== 1'b1 || alloc_index_o !== 5'd7 || read_value_o !== 32'h777 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL realloc7 got ok=%0b idx=%0d val=%h full=%0b exp 1 7 00000777 1",
               alloc_ok_o, alloc_index_o, read_value_o, full_o);
    end
  endtask

  task automatic test_write_search();
    write_enable_i = 1'b1; write_index_i = 5'd2; write_data_i = 32'hA5A5_A5A5;
    search_enable_i = 1'b1; search_data_i = 32'hA5A5_A5A5; search_mask_i = 32'hFFFF_FFFF;
    cycle();
    write_enable_i = 1'b0;
    read_index_i = 5'd2;
    #1;
    checks++;
    if (search_valid_o !== 1'b0 || search_count_o !== 6'd0 || read_value_o !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL write_search got v=%0b c=%0d rd=%h exp 0 0 a5a5a5a5", search_valid_o, search_count_o, read_value_o);
    end
    cycle();
    idle();
    checks++;
    if (search_valid_o !== 1'b1 || search_index_o !== 5'd2 || search_count_o !== 6'd1) begin
      errors++;
      $display("FAIL back_to_back got v=%0b i=%0d c=%0d exp 1 2 1", search_valid_o, search_index_o, search_count_o);
    end
  endtask

  task automatic test_priority();
    // Write beats invalidate on the same index; other invalidate proceeds.
    write_enable_i = 1'b1; write_index_i = 5'd4; write_data_i = 32'h44;
    invalidate_i = 1'b1; invalidate_index_i = 5'd4;
    cycle();
    write_index_i = 5'd6; write_data_i = 32'h66;
    invalidate_index_i = 5'd6;
    cycle();
    idle();
    read_index_i = 5'd4;
    #1;
    checks++;
    if (read_value_o !== 32'h44 || read_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL write_over_inval got %h/%0b exp 00000044/1", read_value_o, read_valid_o);
    end
    invalidate_i = 1'b1; invalidate_index_i = 5'd6;
    write_enable_i = 1'b1; write_index_i = 5'd8; write_data_i = 32'h88;
    cycle();
    idle();
    read_index_i = 5'd6;
    #1;
    checks++;
    if (read_valid_o !== 1'b0 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL parallel_inval got valid=%0b full=%0b exp 0 0", read_valid_o, full_o);
    end
    // Write beats alloc: alloc dropped, free slot 6 stays taken by the write only.
    write_enable_i = 1'b1; write_index_i = 5'd6; write_data_i = 32'h66;
    alloc_i = 1'b1;
    cycle();
    idle();
    #1;
    checks++;
    if (alloc_ok_o !== 1'b0 || read_value_o !== 32'h66 || read_valid_o !== 1'b1 || full_o !== 1'b1) begin
      errors++;
      $display("FAIL write_over_alloc got ok=%0b rd=%h v=%0b full=%0b exp 0 00000066 1 1",
               alloc_ok_o, read_value_o, read_valid_o, full_o);
    end
    // Flush beats write.
    flush_i = 1'b1;
    write_enable_i = 1'b1; write_index_i = 5'd4; write_data_i = 32'h99;
    cycle();
    idle();
    read_index_i = 5'd4;
    search_enable_i = 1'b1; search_mask_i = 32'h0;
    #1;
    checks++;
    if (read_valid_o !== 1'b0 || full_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_write got valid=%0b full=%0b exp 0 0", read_valid_o, full_o);
    end
    cycle();
    idle();
    checks++;
    if (search_valid_o !== 1'b0 || search_count_o !== 6'd0) begin
      errors++;
      $display("FAIL flush_empty got v=%0b c=%0d exp 0 0", search_valid_o, search_count_o);
    end
  endtask

  task automatic test_reset_mid_search();
    write_enable_i = 1'b1; write_index_i = 5'd1; write_data_i = 32'h11;
    cycle();
    idle();
    search_enable_i = 1'b1; search_data_i = 32'h11; search_mask_i = 32'hFFFF_FFFF;
    cycle();
    checks++;
    if (search_valid_o !== 1'b1 || search_index_o !== 5'd1 || search_count_o !== 6'd1) begin
      errors++;
      $display("FAIL pre_reset_hit got v=%0b i=%0d c=%0d exp 1 1 1", search_valid_o, search_index_o, search_count_o);
    end
    #2;
    rst_i = 1'b0;
    read_index_i = 5'd1;
    #1;
    checks++;
    if (search_valid_o !== 1'b0 || search_count_o !== 6'd0 || read_valid_o !== 1'b0 || read_value_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got v=%0b c=%0d rv=%0b rd=%h exp 0 0 0 00000000",
               search_valid_o, search_count_o, read_valid_o, read_value_o);
    end
    idle();
    cycle();
    #2;
    rst_i = 1'b1;
    cycle();
    checks++;
    if (search_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_discard got v=%0b exp 0", search_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_multi_hit();
    test_masked();
    test_alloc();
    test_inval_alloc();
    test_write_search();
    test_priority();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_param.md
Name: cam_param

Overview:
- Parametrised, registered-output content-addressable memory: DEPTH entries of WIDTH bits, each with its own valid bit.
- Adds features the fixed 32x32 CAM does not have:
  - masked (don't-care) search
  - per-entry invalidate and single-cycle flush
  - free-slot auto-allocation with a full flag
  - multi-hit detection with a hit count
- Drop-in search/lookup engine for the CAM validation environment.
- Search results are pipelined one cycle for timing.

Parameters:
- WIDTH, 32, bits per entry and per search key
- DEPTH, 32, number of entries; must be at least 2
- IDX_W, $clog2(DEPTH), index width (derived; not overridden)
- CNT_W, $clog2(DEPTH+1), hit-count width (derived)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- write_enable_i  in  1  write write_data_i to write_index_i; entry becomes valid
- write_index_i  in  IDX_W  target entry for an explicit write
- write_data_i  in  WIDTH  data for an explicit write or an alloc
- alloc_i  in  1  write write_data_i into the lowest-numbered invalid entry
- alloc_ok_o  out  1  registered; 1 = the previous cycle's alloc succeeded
- alloc_index_o  out  IDX_W  registered; entry the previous alloc used
- full_o  out  1  combinational; all entries valid
- invalidate_i  in  1  clear the valid bit of invalidate_index_i
- invalidate_index_i  in  IDX_W  entry to invalidate
- flush_i  in  1  clear all valid bits
- read_index_i  in  IDX_W  combinational read address
- read_value_o  out  WIDTH  data of the addressed entry
- read_valid_o  out  1  valid bit of the addressed entry
- search_enable_i  in  1  launch a search this cycle
- search_data_i  in  WIDTH  search key
- search_mask_i  in  WIDTH  1 = compare this bit, 0 = don't care
- search_valid_o  out  1  registered; 1 = at least one hit
- search_index_o  out  IDX_W  registered; lowest-numbered hit index
- search_multi_o  out  1  registered; 1 = two or more hits
- search_count_o  out  CNT_W  registered; number of hits

Behaviour:
- Reset (rst_i=0, asynchronous):
  - all data registers and valid bits go to 0
  - all registered outputs go to 0
  - full_o=0; read_value_o=0; read_valid_o=0
  - a search or alloc in flight during reset is discarded
- Entry hit rule: the entry is valid and ((entry ^ search_data_i) & search_mask_i) is 0. An all-zero mask hits every valid entry. Invalid entries never hit.
- Search timing:
  - the search samples array state as it stood before the edge (pre-update), so a same-cycle write, alloc, invalidate or flush is not visible to it
  - results are presented for exactly one cycle after the sampling edge
  - in a cycle with no search, all search outputs are 0
  - back-to-back searches are allowed, one result per cycle
- Priority encoding: search_index_o is the lowest hit index, and is 0 when there is no hit. search_count_o saturates naturally because CNT_W holds DEPTH.
- Read path: combinational from current state; reflects a write one cycle after its edge.
- Update priority, per edge:
  1. flush_i clears all valid bits; write, alloc and invalidate are ignored that cycle.
  2. write_enable_i takes precedence over alloc_i. If both are asserted, the alloc is dropped and alloc_ok_o=0 next cycle.
  3. Write and invalidate to the same index: the write wins and the entry is left valid with the new data. Invalidate to a different index proceeds in parallel.
  4. Alloc selects the lowest free entry from pre-edge valid bits, so an entry freed by a same-cycle invalidate is not eligible. Alloc and invalidate to different indices proceed in parallel.
- Alloc result:
  - if full (pre-edge), no write occurs, alloc_ok_o=0 next cycle and alloc_index_o=0
  - on success, alloc_ok_o=1 for one cycle and alloc_index_o = the chosen index
- Writing an already-valid entry overwrites it; duplicate contents are permitted and are reported through search_multi_o.
- full_o tracks the current valid bits; it deasserts in the cycle after an invalidate or flush edge.
- Reads of any index in 0..DEPTH-1 are legal. Behaviour for an index at or above DEPTH (when DEPTH is not a power of 2) is: read_value_o=0, read_valid_o=0, and writes/invalidates to that index are ignored.

Test Plan (WIDTH=32, DEPTH=32):
- Reset then search key 0x0, mask 0xFFFFFFFF:
  - required response is search_valid_o=0, count=0, full_o=0, read_valid_o=0 at every index
- Write 0xDEADBEEF to entry 5 and to entry 9, then search 0xDEADBEEF with a full mask:
  - next cycle search_valid_o=1, search_index_o=5, search_multi_o=1, search_count_o=2
- Write 0x12345678 to entry 3, then search 0x12340000 with mask 0xFFFF0000:
  - required response is a hit at index 3
  - same key with mask 0xFFFFFFFF gives no hit
- Alloc 32 times with data i:
  - alloc_index_o runs 0..31 with alloc_ok_o=1 each time; full_o=1 after the last
  - a 33rd alloc gives alloc_ok_o=0, no data changed
- While full, invalidate entry 7 and alloc in the same cycle:
  - the alloc fails (pre-edge full)
  - a following alloc gets index 7
- Write 0xA5A5A5A5 to entry 2 while searching 0xA5A5A5A5 in the same cycle:
  - the search misses and read_value_o(2)=0xA5A5A5A5 next cycle
  - flush plus write in the same cycle leaves all entries invalid
  - asserting rst_i low mid-search zeroes search_valid_o immediately
